// File: rtl/fmadd_iter_mul.sv
// Iterative single-precision multiplier front end: shift-add product, normalise/denormalise,
// and hand an unrounded {sign, 9-bit exponent, 48-bit mantissa} plus sticky to the rounding stage.
module fmadd_iter_mul #(
  parameter int std  = 31,
  parameter int man  = 22,
  parameter int exp  = 7,
  parameter int biad = 127
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [std:0]           in_a,
  input  logic [std:0]           in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [man+man+exp+6:0] out_no,
  output logic                   out_sticky_PN
);

  localparam int SW  = man + 2;
  localparam int PW  = 2 * SW;
  localparam int EW  = 11;
  localparam int XW  = exp + 1;
  localparam int OEW = exp + 2;
  localparam int CW  = 6;
  localparam int CIW = $clog2(SW);

  localparam logic [OEW-1:0]       EXP_OVF = {1'b1, {(OEW-1){1'b0}}};
  localparam logic signed [EW-1:0] E_MAX   = EW'((1 << XW) - 1);
  localparam logic signed [EW-1:0] E_ONE   = EW'(1);

  typedef enum logic [2:0] {IDLE, MUL, NORM, DENORM, DONE} state_t;

  state_t state_q, state_d;

  logic [SW-1:0]        a_sig_q, a_sig_d, b_sig_q, b_sig_d;
  logic                 sign_q, sign_d;
  logic signed [EW-1:0] e_q, e_d;
  logic [PW-1:0]        p_q, p_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sticky_q, sticky_d;
  logic [OEW-1:0]       oexp_q, oexp_d;

  // Operand unpack
  logic [XW-1:0]        ea_raw, eb_raw, ea_eff, eb_eff;
  logic [SW-1:0]        a_sig_in, b_sig_in;
  logic                 sign_in, spec_in, zero_in;
  logic signed [EW-1:0] e_load;

  always_comb begin
    ea_raw   = in_a[std-1:man+1];
    eb_raw   = in_b[std-1:man+1];
    ea_eff   = (ea_raw == '0) ? XW'(1) : ea_raw;
    eb_eff   = (eb_raw == '0) ? XW'(1) : eb_raw;
    a_sig_in = {|ea_raw, in_a[man:0]};
    b_sig_in = {|eb_raw, in_b[man:0]};
    sign_in  = in_a[std] ^ in_b[std];
    spec_in  = (&ea_raw) | (&eb_raw);
    zero_in  = ((ea_raw == '0) && (in_a[man:0] == '0)) ||
               ((eb_raw == '0) && (in_b[man:0] == '0));
    e_load   = EW'(ea_eff) + EW'(eb_eff) - EW'(biad);
  end

  // Per-state datapath steps
  logic [SW:0]          mul_sum;
  logic [PW-1:0]        p_mul, p_norm, p_den;
  logic signed [EW-1:0] e_norm, e_den;
  logic [CW-1:0]        cnt_den;
  logic                 sticky_den, norm_more, norm_under, den_end;

  always_comb begin
    mul_sum = {1'b0, p_q[PW-1:SW]} + (b_sig_q[cnt_q[CIW-1:0]] ? {1'b0, a_sig_q} : '0);
    p_mul   = {mul_sum, p_q[SW-1:1]};

    // cnt_q is 0 only on the first NORM cycle; later cycles are only reached when a shift is due
    if (cnt_q == '0) begin
      if (p_q[PW-1]) begin
        p_norm = p_q;
        e_norm = e_q + E_ONE;
      end else begin
        p_norm = p_q << 1;
        e_norm = e_q;
      end
    end else begin
      p_norm = p_q << 1;
      e_norm = e_q - E_ONE;
    end
    norm_more  = !p_norm[PW-1] && (p_norm != '0) && (e_norm > E_ONE);
    norm_under = e_norm < E_ONE;

    p_den      = p_q >> 1;
    sticky_den = sticky_q | p_q[0];
    e_den      = e_q + E_ONE;
    cnt_den    = cnt_q + CW'(1);
    den_end    = (e_den >= E_ONE) || (cnt_den == CW'(PW));
  end

  function automatic logic [OEW-1:0] enc_exp(input logic signed [EW-1:0] e, input logic msb);
    if (e >= E_MAX)  return EXP_OVF;
    else if (!msb)   return '0;
    else             return e[OEW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_l) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = (spec_in || zero_in) ? DONE : MUL;
      MUL:     if (cnt_q == CW'(SW-1)) state_d = NORM;
      NORM:    if (!norm_more) state_d = norm_under ? DENORM : DONE;
      DENORM:  if (den_end) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready      = (state_q == IDLE);
    out_valid     = (state_q == DONE);
    out_no        = '0;
    out_sticky_PN = 1'b0;
    if (state_q == DONE) begin
      out_no        = {sign_q, oexp_q, p_q};
      out_sticky_PN = sticky_q;
    end
  end

  always_comb begin
    a_sig_d  = a_sig_q;
    b_sig_d  = b_sig_q;
    sign_d   = sign_q;
    e_d      = e_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    oexp_d   = oexp_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        a_sig_d  = a_sig_in;
        b_sig_d  = b_sig_in;
        sign_d   = sign_in;
        e_d      = e_load;
        p_d      = '0;
        cnt_d    = '0;
        sticky_d = 1'b0;
        oexp_d   = spec_in ? EXP_OVF : '0;
      end
      MUL: begin
        p_d   = p_mul;
        cnt_d = (cnt_q == CW'(SW-1)) ? '0 : cnt_q + CW'(1);
      end
      NORM: begin
        p_d   = p_norm;
        e_d   = e_norm;
        cnt_d = norm_more ? CW'(1) : '0;
        if (!norm_more && !norm_under) oexp_d = enc_exp(e_norm, p_norm[PW-1]);
      end
      DENORM: begin
        p_d      = p_den;
        e_d      = e_den;
        sticky_d = sticky_den;
        cnt_d    = cnt_den;
        if (den_end) oexp_d = enc_exp(e_den, p_den[PW-1]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      a_sig_q  <= '0;
      b_sig_q  <= '0;
      sign_q   <= 1'b0;
      e_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      oexp_q   <= '0;
    end else begin
      a_sig_q  <= a_sig_d;
      b_sig_q  <= b_sig_d;
      sign_q   <= sign_d;
      e_q      <= e_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      oexp_q   <= oexp_d;
    end
  end

endmodule

// File: tb/tb_fmadd_iter_mul.sv
// Directed bench for fmadd_iter_mul: hand-computed products, latencies, backpressure and reset.
module tb_fmadd_iter_mul;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [57:0] out_no;
  logic        out_sticky_PN;

  int n_cmp = 0;
  int n_bad = 0;

  fmadd_iter_mul #(.std(31), .man(22), .exp(7), .biad(127)) dut (
    .clk(clk), .rst_l(rst_l),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_no(out_no), .out_sticky_PN(out_sticky_PN)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, expv);
    end
  endtask

  // Called #1 after an edge while idle; returns when out_valid is seen or the budget runs out.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [57:0] res, output logic stk, output int lat);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_no;
    stk = out_sticky_PN;
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [57:0] res;
    logic [57:0] mask;
    logic        stk;
    int          lat;
  } vec_t;

  localparam logic [57:0] ALL   = '1;
  localparam logic [57:0] EXPMK = {1'b0, 9'h1FF, 48'h0};

  vec_t vecs[$];

  initial begin
    logic [57:0] res;
    logic        stk;
    int          lat;
    int          seen;

    vecs.push_back('{a:32'h3F800000, b:32'h3F800000, res:{1'b0, 9'd127, 48'h800000000000}, mask:ALL,   stk:1'b0, lat:26});
    vecs.push_back('{a:32'h3FC00000, b:32'h3FC00000, res:{1'b0, 9'd128, 48'h900000000000}, mask:ALL,   stk:1'b0, lat:26});
    vecs.push_back('{a:32'h00800000, b:32'h3F000000, res:{1'b0, 9'd0,   48'h400000000000}, mask:ALL,   stk:1'b0, lat:27});
    vecs.push_back('{a:32'h7F000000, b:32'h7F000000, res:{1'b0, 9'h100, 48'h0},            mask:EXPMK, stk:1'b0, lat:26});
    vecs.push_back('{a:32'h00000000, b:32'hC0000000, res:{1'b1, 9'd0,   48'h0},            mask:ALL,   stk:1'b0, lat:1});
    vecs.push_back('{a:32'h7F800000, b:32'h3F800000, res:{1'b0, 9'h100, 48'h0},            mask:ALL,   stk:1'b0, lat:1});
    vecs.push_back('{a:32'h00400000, b:32'h7E800000, res:{1'b0, 9'd126, 48'h800000000000}, mask:ALL,   stk:1'b0, lat:27});
    vecs.push_back('{a:32'h00400000, b:32'h3F800000, res:{1'b0, 9'd0,   48'h400000000000}, mask:ALL,   stk:1'b0, lat:26});
    vecs.push_back('{a:32'h00800001, b:32'h00800000, res:{1'b0, 9'd0,   48'h0},            mask:ALL,   stk:1'b1, lat:74});

    rst_l = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready",  64'(in_ready),  64'd1);
    chk("rst out_no",    64'(out_no),    64'd0);
    chk("rst sticky",    64'(out_sticky_PN), 64'd0);
    rst_l = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, res, stk, lat);
      chk($sformatf("vec%0d out_no", i),  64'(res & vecs[i].mask), 64'(vecs[i].res & vecs[i].mask));
      chk($sformatf("vec%0d sticky", i),  64'(stk), 64'(vecs[i].stk));
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      release_op();
      chk($sformatf("vec%0d idle", i), 64'(in_ready), 64'd1);
    end

    // Backpressure: 2.0 x 3.0 held in DONE while new operands are offered and must be ignored
    run_op(32'h40000000, 32'h40400000, res, stk, lat);
    chk("bp result",  64'(res), 64'({1'b0, 9'd129, 48'hC00000000000}));
    chk("bp latency", 64'(lat), 64'd26);
    in_a = 32'h3FC00000; in_b = 32'h3FC00000;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d out_no", c),   64'(out_no),    64'({1'b0, 9'd129, 48'hC00000000000}));
      chk($sformatf("bp hold%0d in_ready", c), 64'(in_ready),  64'd0);
      chk($sformatf("bp hold%0d valid", c),    64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    release_op();
    chk("bp release valid", 64'(out_valid), 64'd0);
    chk("bp release ready", 64'(in_ready),  64'd1);

    // Reset mid-MUL at T+10
    in_a = 32'h3F800000; in_b = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_l = 1'b0;
    @(posedge clk); #1;
    rst_l = 1'b1;
    chk("mulrst valid",  64'(out_valid), 64'd0);
    chk("mulrst ready",  64'(in_ready),  64'd1);
    chk("mulrst out_no", 64'(out_no),    64'd0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mulrst no partial", 64'(seen), 64'd0);

    // Reset mid-DENORM, then recovery
    in_a = 32'h00800001; in_b = 32'h00800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    rst_l = 1'b0;
    @(posedge clk); #1;
    rst_l = 1'b1;
    chk("denrst valid",  64'(out_valid), 64'd0);
    chk("denrst ready",  64'(in_ready),  64'd1);
    chk("denrst sticky", 64'(out_sticky_PN), 64'd0);

    run_op(32'h3FC00000, 32'h3FC00000, res, stk, lat);
    chk("recover out_no",  64'(res), 64'({1'b0, 9'd128, 48'h900000000000}));
    chk("recover latency", 64'(lat), 64'd26);
    release_op();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
